// File: rtl/gerenciador_de_posicionamento.sv
// Ship placement manager: builds the 5x7 ship map one confirmed cell at a time.
// Optional macro REMOVER_CELULA_EN lets a confirm on an occupied cell remove it.
module gerenciador_de_posicionamento #(
  parameter int NUM_CELULAS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       enable,
  input  logic       confirmar,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic       pronto,
  output logic [2:0] restantes
);

  typedef enum logic [1:0] {
    OCIOSO,
    POSICIONANDO,
    PRONTO
  } estado_t;

  localparam logic [2:0] TOTAL = 3'(NUM_CELULAS);

  estado_t         estado, estado_n;
  logic [4:0][6:0] mapa, mapa_n;
  logic            led_r_n, led_g_n;
  logic [2:0]      rest_n;
  logic            confirmar_q;
  logic            evento;
  logic            valido;
  logic            ocupado;
  logic [6:0]      linha_oh;
  logic [6:0]      col_atual;

  assign evento   = confirmar & ~confirmar_q;
  assign valido   = (coordColuna <= 3'd4) && (coordLinha <= 3'd6);
  assign linha_oh = 7'b1 << coordLinha;
  assign ocupado  = valido && |(col_atual & linha_oh);

  always_comb begin
    col_atual = '0;
    for (int c = 0; c < 5; c++)
      if (coordColuna == 3'(c)) col_atual = mapa[c];
  end

  always_comb begin
    estado_n = estado;
    mapa_n   = mapa;
    led_r_n  = LED_R;
    led_g_n  = LED_G;
    rest_n   = restantes;
    unique case (estado)
      OCIOSO: begin
        mapa_n  = '0;
        led_r_n = 1'b0;
        led_g_n = 1'b0;
        rest_n  = TOTAL;
        if (enable) estado_n = POSICIONANDO;
      end
      POSICIONANDO: begin
        // enable dropping beats a simultaneous event
        if (!enable) begin
          estado_n = OCIOSO;
          mapa_n   = '0;
          led_r_n  = 1'b0;
          led_g_n  = 1'b0;
          rest_n   = TOTAL;
        end else if (evento) begin
          if (!valido) begin
            led_r_n = 1'b1;
            led_g_n = 1'b0;
          end else if (ocupado) begin
`ifdef REMOVER_CELULA_EN
            for (int c = 0; c < 5; c++)
              if (coordColuna == 3'(c)) mapa_n[c] = mapa[c] & ~linha_oh;
            rest_n  = restantes + 3'd1;
            led_r_n = 1'b1;
            led_g_n = 1'b1;
`else
            led_r_n = 1'b1;
            led_g_n = 1'b0;
`endif
          end else begin
            for (int c = 0; c < 5; c++)
              if (coordColuna == 3'(c)) mapa_n[c] = mapa[c] | linha_oh;
            rest_n  = restantes - 3'd1;
            led_r_n = 1'b0;
            led_g_n = 1'b1;
            if (restantes == 3'd1) begin
              estado_n = PRONTO;
              led_r_n  = 1'b0;
              led_g_n  = 1'b0;
            end
          end
        end
      end
      PRONTO: begin
        led_r_n = 1'b0;
        led_g_n = 1'b0;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      mapa        <= '0;
      LED_R       <= 1'b0;
      LED_G       <= 1'b0;
      restantes   <= TOTAL;
      confirmar_q <= 1'b0;
    end else begin
      estado      <= estado_n;
      mapa        <= mapa_n;
      LED_R       <= led_r_n;
      LED_G       <= led_g_n;
      restantes   <= rest_n;
      confirmar_q <= confirmar;
    end
  end

  assign pronto = (estado == PRONTO);
  assign LED_B  = (estado == PRONTO);
  assign mapa0  = mapa[0];
  assign mapa1  = mapa[1];
  assign mapa2  = mapa[2];
  assign mapa3  = mapa[3];
  assign mapa4  = mapa[4];

endmodule

// File: doc/gerenciador_de_posicionamento.md
Name: gerenciador_de_posicionamento

Overview:
- Builds the ship map (mapa0..mapa4) during the placement phase.
- The player moves a cursor with coordColuna/coordLinha and presses confirmar to mark ship cells, one at a time.
- Valid cells are written into a 5-column x 7-row bit map; invalid or repeated cells are refused. Status is shown on the RGB LEDs.
- When NUM_CELULAS cells are placed, the map is frozen and `pronto` is raised. The map feeds the attack manager's mapa inputs for the attack phase.

Parameters:
- NUM_CELULAS, 5, number of ship cells to place before the map is frozen (legal range 1..7).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- coordColuna  input  3  cursor column; valid 0..4.
- coordLinha  input  3  cursor row; valid 0..6.
- enable  input  1  placement phase enable, level.
- confirmar  input  1  confirm button, level; one event per rising transition.
- mapa0..mapa4  output  7 each  column maps; bit i is row i; 1 = ship cell.
- LED_R  output  1  last confirm was refused.
- LED_G  output  1  last confirm was accepted.
- LED_B  output  1  map complete.
- pronto  output  1  map frozen and valid.
- restantes  output  3  cells still to place.

Behaviour:
- Reset values:
  - mapa0..4 = 0, LED_R = LED_G = LED_B = 0, pronto = 0.
  - restantes = NUM_CELULAS, internal confirmar history flop = 0, state = OCIOSO.
- Confirm event:
  - evento = confirmar & ~confirmar_q, where confirmar_q is confirmar registered on every clock.
  - Holding confirmar high gives exactly one event.
  - No debouncing is done in this block.
- Latency: all updates caused by an event are visible right after the rising edge at which evento = 1 (one cycle from confirmar rising at the sampling edge).
- State OCIOSO:
  - Maps = 0, LEDs = 0, restantes = NUM_CELULAS.
  - enable=1 -> POSICIONANDO on the next edge.
  - Events are ignored.
- State POSICIONANDO, on evento:
  - Coordinate out of range (coordColuna > 4 or coordLinha > 6): refuse; LED_R=1, LED_G=0, maps unchanged.
  - Addressed bit already 1: refuse; LED_R=1, LED_G=0.
  - Otherwise: set mapa[coordColuna][coordLinha]=1, LED_R=0, LED_G=1, restantes decrements by 1.
  - If restantes reaches 0 at this edge, go to PRONTO on the same edge.
  - LEDs hold their value between events.
- State PRONTO:
  - pronto=1, LED_B=1, LED_R=LED_G=0; maps held.
  - Events and enable are ignored.
  - Only reset leaves PRONTO, so the map survives enable dropping when the attack phase starts.
- enable=0 while in POSICIONANDO: return to OCIOSO on the next edge and clear partial progress.
- enable falling in the same cycle as evento: enable wins; the event is discarded and the block goes to OCIOSO.
- Reset asserted mid-operation clears everything asynchronously, with no clock needed. The first event after release needs confirmar to go low, then high.
- Width rules:
  - restantes never wraps below 0 or above NUM_CELULAS.
  - Map bit count always equals NUM_CELULAS - restantes.

Optional Feature:
- Macro: REMOVER_CELULA_EN.
- Defined: in POSICIONANDO, an event on an occupied valid cell clears that bit, increments restantes and sets LED_R=1 and LED_G=1 (yellow = removed).
- Not defined: the same event is refused as an occupied cell (LED_R=1, LED_G=0, map unchanged).

Test Plan:
- Test 1, single placement:
  - Stimulus: reset, enable=1, confirm at col 0 / row 0.
  - Response: mapa0=7'b0000001, LED_G=1, LED_R=0, restantes=4, pronto=0.
- Test 2, repeated and out-of-range cells (macro off):
  - Stimulus: confirm (0,0) again; then col 5 / row 2; then col 1 / row 7.
  - Response: each event gives LED_R=1, LED_G=0; maps unchanged; restantes stays 4.
- Test 3, filling the map:
  - Stimulus: place (0,0), (1,5), (3,5), (4,6), (4,5).
  - Response: mapa0=0000001, mapa1=0100000, mapa2=0000000, mapa3=0100000, mapa4=1100000; restantes=0, pronto=1, LED_B=1.
  - Follow-up: confirm at (2,2), then drop enable; maps remain unchanged.
- Test 4, held button: confirmar held high for 10 cycles at (2,3) -> exactly one placement; mapa2=0001000, restantes decrements once.
- Test 5, enable drop and reset mid-operation:
  - After 2 placements, enable=0 -> next edge: maps=0, restantes=5, LEDs=0.
  - Re-place a cell, then pulse reset between clock edges -> outputs clear before the next edge.
- Test 6, removal (REMOVER_CELULA_EN defined): place (3,4), confirm (3,4) again -> mapa3=0, restantes back to 5, LED_R=LED_G=1.
